// File: rtl/vx_commit_pkg.sv
// Shared types, widths and helpers for the ALU commit receive path.
package vx_commit_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned NR_BITS     = 6;
  localparam int unsigned UUID_BITS   = 44;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned DATA_W      = NUM_THREADS * 32;
  localparam int unsigned RET_CNT_W   = 64;
  localparam int unsigned PERF_CNT_W  = 32;
  localparam int unsigned LANE_CNT_W  = $clog2(NUM_THREADS + 1);

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic [NR_BITS-1:0]     rd;
    logic                   wb;
    logic [DATA_W-1:0]      data;
    logic                   eop;
  } commit_entry_t;

  // Number of active lanes in a thread mask.
  function automatic logic [LANE_CNT_W-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [LANE_CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      sum = sum + LANE_CNT_W'(mask[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/vx_commit_fifo.sv
// Registered elastic FIFO of commit entries with a registered accept flag.
module vx_commit_fifo
  import vx_commit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  commit_entry_t i_push_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ready,
  output commit_entry_t o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  commit_entry_t    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_ready;
  logic [PW-1:0]    w_count;
  logic [PW-1:0]    w_count_next;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit separates full from empty.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign o_full       = (w_count == PW'(DEPTH));
  assign o_empty      = (w_count == '0);
  assign w_push       = i_push && !o_full;
  assign w_pop        = i_pop && !o_empty;
  assign w_count_next = w_count + PW'(w_push) - PW'(w_pop);
  assign o_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign o_ready      = r_ready;

  // Pointer and accept-flag update; accept flag looks one cycle ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_ready <= (w_count_next != PW'(DEPTH));
    end
  end

  // Storage; cleared on reset so the head never shows stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/vx_alu_commit_rx.sv
// ALU commit stream receiver: FIFO, GPR write port, scoreboard release, retire counters.
// Optional stall perf counters enabled by defining VX_COMMIT_RX_PERF_EN.
module vx_alu_commit_rx
  import vx_commit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic [UUID_BITS-1:0]   commit_uuid,
  input  logic [NW_BITS-1:0]     commit_wid,
  input  logic [NUM_THREADS-1:0] commit_tmask,
  input  logic [PC_W-1:0]        commit_PC,
  input  logic [NR_BITS-1:0]     commit_rd,
  input  logic                   commit_wb,
  input  logic [DATA_W-1:0]      commit_data,
  input  logic                   commit_eop,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [NW_BITS-1:0]     wb_wid,
  output logic [NR_BITS-1:0]     wb_rd,
  output logic [NUM_THREADS-1:0] wb_tmask,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   release_valid,
  output logic [NW_BITS-1:0]     release_wid,
  output logic [NR_BITS-1:0]     release_rd,
  output logic [RET_CNT_W-1:0]   instr_retired,
  output logic [RET_CNT_W-1:0]   lanes_retired,
  output logic [PERF_CNT_W-1:0]  stall_in_cycles,
  output logic [PERF_CNT_W-1:0]  stall_wb_cycles
);

  commit_entry_t          w_in;
  commit_entry_t          w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_wb_valid;
  logic                   w_retire;
  logic                   w_unused_trace;
  logic                   r_rel_valid;
  logic [NW_BITS-1:0]     r_rel_wid;
  logic [NR_BITS-1:0]     r_rel_rd;
  logic [RET_CNT_W-1:0]   r_instr;
  logic [RET_CNT_W-1:0]   r_lanes;

  assign w_in = '{uuid: commit_uuid, wid: commit_wid, tmask: commit_tmask, PC: commit_PC,
                  rd: commit_rd, wb: commit_wb, data: commit_data, eop: commit_eop};

  vx_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_push      (w_push),
    .i_push_data (w_in),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ready     (w_ready),
    .o_head      (w_head)
  );

  // Non-writing entries drain on their own; writing entries wait for the GPR port.
  assign w_push     = commit_valid && w_ready;
  assign w_wb_valid = !w_empty && w_head.wb;
  assign w_pop      = !w_empty && (!w_head.wb || wb_ready);
  assign w_retire   = w_pop && w_head.eop;

  assign commit_ready = w_ready;
  assign wb_valid     = w_wb_valid;
  assign wb_wid       = w_wb_valid ? w_head.wid   : '0;
  assign wb_rd        = w_wb_valid ? w_head.rd    : '0;
  assign wb_tmask     = w_wb_valid ? w_head.tmask : '0;
  assign wb_data      = w_wb_valid ? w_head.data  : '0;

  // uuid/PC ride along for tracing only.
  assign w_unused_trace = ^{w_head.uuid, w_head.PC, w_full};

  // Scoreboard release one cycle after the last beat of a writing instruction pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rel_valid <= 1'b0;
      r_rel_wid   <= '0;
      r_rel_rd    <= '0;
    end else begin
      r_rel_valid <= w_retire && w_head.wb;
      r_rel_wid   <= (w_retire && w_head.wb) ? w_head.wid : '0;
      r_rel_rd    <= (w_retire && w_head.wb) ? w_head.rd  : '0;
    end
  end

  assign release_valid = r_rel_valid;
  assign release_wid   = r_rel_wid;
  assign release_rd    = r_rel_rd;

  // Retirement counters, wrapping modulo 2^64.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= '0;
      r_lanes <= '0;
    end else if (w_retire) begin
      r_instr <= r_instr + RET_CNT_W'(1);
      r_lanes <= r_lanes + RET_CNT_W'(popcount(w_head.tmask));
    end
  end

  assign instr_retired = r_instr;
  assign lanes_retired = r_lanes;

`ifdef VX_COMMIT_RX_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_in;
  logic [PERF_CNT_W-1:0] r_stall_wb;

  // Saturating stall counters for input backpressure and GPR port backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_in <= '0;
      r_stall_wb <= '0;
    end else begin
      if (commit_valid && !w_ready && (r_stall_in != '1)) r_stall_in <= r_stall_in + PERF_CNT_W'(1);
      if (w_wb_valid && !wb_ready && (r_stall_wb != '1)) r_stall_wb <= r_stall_wb + PERF_CNT_W'(1);
    end
  end

  assign stall_in_cycles = r_stall_in;
  assign stall_wb_cycles = r_stall_wb;
`else
  assign stall_in_cycles = '0;
  assign stall_wb_cycles = '0;
`endif

endmodule

// File: tb/tb_vx_alu_commit_rx.sv
// Directed self-checking bench for vx_alu_commit_rx.
module tb_vx_alu_commit_rx;
  import vx_commit_pkg::*;

  logic                   clk;
  logic                   reset_n;
  logic                   commit_valid;
  logic                   commit_ready;
  logic [UUID_BITS-1:0]   commit_uuid;
  logic [NW_BITS-1:0]     commit_wid;
  logic [NUM_THREADS-1:0] commit_tmask;
  logic [PC_W-1:0]        commit_PC;
  logic [NR_BITS-1:0]     commit_rd;
  logic                   commit_wb;
  logic [DATA_W-1:0]      commit_data;
  logic                   commit_eop;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [NW_BITS-1:0]     wb_wid;
  logic [NR_BITS-1:0]     wb_rd;
  logic [NUM_THREADS-1:0] wb_tmask;
  logic [DATA_W-1:0]      wb_data;
  logic                   release_valid;
  logic [NW_BITS-1:0]     release_wid;
  logic [NR_BITS-1:0]     release_rd;
  logic [RET_CNT_W-1:0]   instr_retired;
  logic [RET_CNT_W-1:0]   lanes_retired;
  logic [PERF_CNT_W-1:0]  stall_in_cycles;
  logic [PERF_CNT_W-1:0]  stall_wb_cycles;

  int checks = 0;
  int errors = 0;
  int uuid_ctr = 0;
  logic [DATA_W-1:0] held_data;

  vx_alu_commit_rx dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .commit_valid    (commit_valid),
    .commit_ready    (commit_ready),
    .commit_uuid     (commit_uuid),
    .commit_wid      (commit_wid),
    .commit_tmask    (commit_tmask),
    .commit_PC       (commit_PC),
    .commit_rd       (commit_rd),
    .commit_wb       (commit_wb),
    .commit_data     (commit_data),
    .commit_eop      (commit_eop),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_wid          (wb_wid),
    .wb_rd           (wb_rd),
    .wb_tmask        (wb_tmask),
    .wb_data         (wb_data),
    .release_valid   (release_valid),
    .release_wid     (release_wid),
    .release_rd      (release_rd),
    .instr_retired   (instr_retired),
    .lanes_retired   (lanes_retired),
    .stall_in_cycles (stall_in_cycles),
    .stall_wb_cycles (stall_wb_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int wid, input int rd, input logic wb, input logic eop,
                       input logic [NUM_THREADS-1:0] tm, input logic [DATA_W-1:0] data);
    commit_valid = 1'b1;
    commit_uuid  = UUID_BITS'(uuid_ctr);
    commit_PC    = PC_W'(32'h1000 + 4 * uuid_ctr);
    commit_wid   = NW_BITS'(wid);
    commit_rd    = NR_BITS'(rd);
    commit_wb    = wb;
    commit_eop   = eop;
    commit_tmask = tm;
    commit_data  = data;
    uuid_ctr++;
  endtask

  task automatic idle();
    commit_valid = 1'b0;
    commit_wb    = 1'b0;
    commit_eop   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_ready = 1'b1;
    commit_uuid = '0; commit_PC = '0; commit_wid = '0; commit_rd = '0;
    commit_tmask = '0; commit_data = '0;
    idle();

    // Reset state
    tick(); tick();
    check("rst_ready", 128'(commit_ready), 128'(0));
    check("rst_wb_valid", 128'(wb_valid), 128'(0));
    check("rst_release", 128'(release_valid), 128'(0));
    check("rst_instr", 128'(instr_retired), 128'(0));
    check("rst_lanes", 128'(lanes_retired), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_pre_edge", 128'(commit_ready), 128'(0));
    tick();
    check("ready_after_rst", 128'(commit_ready), 128'(1));

    // Single beat
    drive(1, 5, 1'b1, 1'b1, 4'b1011, 128'h1234);
    tick();
    idle();
    check("t1_wb_valid", 128'(wb_valid), 128'(1));
    check("t1_wb_rd", 128'(wb_rd), 128'(5));
    check("t1_wb_wid", 128'(wb_wid), 128'(1));
    check("t1_wb_tmask", 128'(wb_tmask), 128'(4'b1011));
    check("t1_wb_data", 128'(wb_data), 128'h1234);
    check("t1_rel_early", 128'(release_valid), 128'(0));
    tick();
    check("t1_wb_done", 128'(wb_valid), 128'(0));
    check("t1_rel_valid", 128'(release_valid), 128'(1));
    check("t1_rel_wid", 128'(release_wid), 128'(1));
    check("t1_rel_rd", 128'(release_rd), 128'(5));
    check("t1_instr", 128'(instr_retired), 128'(1));
    check("t1_lanes", 128'(lanes_retired), 128'(3));
    tick();
    check("t1_rel_pulse", 128'(release_valid), 128'(0));

    // Back-to-back 8 beats at full rate
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        check("t2_ready", 128'(commit_ready), 128'(1));
        drive(k % 4, 10 + k, 1'b1, 1'b1, 4'hF, {4{32'(k)}});
      end else begin
        idle();
      end
      tick();
      if (k < 8) begin
        check("t2_wb_valid", 128'(wb_valid), 128'(1));
        check("t2_wb_rd", 128'(wb_rd), 128'(10 + k));
        check("t2_wb_wid", 128'(wb_wid), 128'(k % 4));
      end else begin
        check("t2_wb_idle", 128'(wb_valid), 128'(0));
      end
      if (k > 0) begin
        check("t2_rel_valid", 128'(release_valid), 128'(1));
        check("t2_rel_rd", 128'(release_rd), 128'(10 + k - 1));
      end
    end
    check("t2_instr", 128'(instr_retired), 128'(9));
    check("t2_lanes", 128'(lanes_retired), 128'(35));
    tick();

    // GPR port stalled, three beats offered
    wb_ready = 1'b0;
    drive(2, 20, 1'b1, 1'b1, 4'b0011, 128'hA0);
    tick();
    drive(2, 21, 1'b1, 1'b1, 4'b0011, 128'hA1);
    tick();
    drive(2, 22, 1'b1, 1'b1, 4'b0011, 128'hA2);
    tick();
    check("t3_ready_full", 128'(commit_ready), 128'(0));
    check("t3_wb_valid", 128'(wb_valid), 128'(1));
    check("t3_wb_rd", 128'(wb_rd), 128'(20));
    held_data = wb_data;
    tick(); tick();
    check("t3_ready_still", 128'(commit_ready), 128'(0));
    check("t3_rd_stable", 128'(wb_rd), 128'(20));
    check("t3_data_stable", 128'(wb_data), 128'(held_data));
    check("t3_data_val", 128'(wb_data), 128'hA0);
`ifdef VX_COMMIT_RX_PERF_EN
    check("t3_stall_in_nz", 128'(stall_in_cycles != 0), 128'(1));
    check("t3_stall_wb_nz", 128'(stall_wb_cycles != 0), 128'(1));
`else
    check("t3_stall_in_off", 128'(stall_in_cycles), 128'(0));
    check("t3_stall_wb_off", 128'(stall_wb_cycles), 128'(0));
`endif
    wb_ready = 1'b1;
    tick();
    check("t3_drain_rd1", 128'(wb_rd), 128'(21));
    check("t3_ready_back", 128'(commit_ready), 128'(1));
    tick();
    idle();
    check("t3_drain_rd2", 128'(wb_rd), 128'(22));
    check("t3_drain_wbv", 128'(wb_valid), 128'(1));
    tick();
    check("t3_drained", 128'(wb_valid), 128'(0));
    check("t3_instr", 128'(instr_retired), 128'(12));
    check("t3_lanes", 128'(lanes_retired), 128'(41));
    tick();

    // No-write beat retires without write or release
    drive(0, 30, 1'b0, 1'b1, 4'b0111, 128'hBEEF);
    tick();
    idle();
    check("t4_no_wb", 128'(wb_valid), 128'(0));
    tick();
    check("t4_instr", 128'(instr_retired), 128'(13));
    check("t4_lanes", 128'(lanes_retired), 128'(44));
    check("t4_no_rel", 128'(release_valid), 128'(0));
    tick();
    check("t4_no_rel2", 128'(release_valid), 128'(0));

    // Two-beat instruction
    drive(2, 40, 1'b1, 1'b0, 4'hF, 128'hC0);
    tick();
    check("t5_wb1", 128'(wb_valid), 128'(1));
    check("t5_wb1_rd", 128'(wb_rd), 128'(40));
    drive(2, 40, 1'b1, 1'b1, 4'hF, 128'hC1);
    tick();
    idle();
    check("t5_no_rel_mid", 128'(release_valid), 128'(0));
    check("t5_instr_mid", 128'(instr_retired), 128'(13));
    check("t5_wb2", 128'(wb_valid), 128'(1));
    check("t5_wb2_data", 128'(wb_data), 128'hC1);
    tick();
    check("t5_rel", 128'(release_valid), 128'(1));
    check("t5_rel_wid", 128'(release_wid), 128'(2));
    check("t5_rel_rd", 128'(release_rd), 128'(40));
    check("t5_instr", 128'(instr_retired), 128'(14));
    check("t5_lanes", 128'(lanes_retired), 128'(48));
    tick();

    // Reset while full
    wb_ready = 1'b0;
    drive(1, 50, 1'b1, 1'b1, 4'hF, 128'hD0);
    tick();
    drive(1, 51, 1'b1, 1'b1, 4'hF, 128'hD1);
    tick();
    idle();
    check("t6_full", 128'(commit_ready), 128'(0));
    check("t6_wbv_pre", 128'(wb_valid), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_wbv_async", 128'(wb_valid), 128'(0));
    check("t6_rel_async", 128'(release_valid), 128'(0));
    check("t6_instr_clr", 128'(instr_retired), 128'(0));
    check("t6_lanes_clr", 128'(lanes_retired), 128'(0));
    check("t6_stall_in_clr", 128'(stall_in_cycles), 128'(0));
    check("t6_stall_wb_clr", 128'(stall_wb_cycles), 128'(0));
    tick();
    check("t6_ready_in_rst", 128'(commit_ready), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    wb_ready = 1'b1;
    tick();
    check("t6_ready_again", 128'(commit_ready), 128'(1));
    check("t6_empty", 128'(wb_valid), 128'(0));
    drive(3, 60, 1'b1, 1'b1, 4'b0001, 128'hE0);
    tick();
    idle();
    check("t6_wb_new", 128'(wb_valid), 128'(1));
    check("t6_wb_new_rd", 128'(wb_rd), 128'(60));
    tick();
    check("t6_rel", 128'(release_valid), 128'(1));
    check("t6_rel_wid", 128'(release_wid), 128'(3));
    check("t6_rel_rd", 128'(release_rd), 128'(60));
    check("t6_instr", 128'(instr_retired), 128'(1));
    check("t6_lanes", 128'(lanes_retired), 128'(1));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
